// File: rtl/music_sequencer_if.sv
// Score ROM bus between the sequencer (master) and a synchronous score ROM (slave).
// rom_data is valid the cycle after rom_rd is sampled high.
interface music_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [9:0]        rom_data;

    modport master (output rom_addr, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_rd, output rom_data);
endinterface

// File: rtl/music_sequencer.sv
// Score sequencer: fetches {end, note, duration} words from the score ROM, times each
// note in beats and drives the registered note code for the downstream tone generator.
module music_sequencer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BEAT_HZ = 8,
    parameter int ADDR_W  = 8,
    parameter int GAP_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    music_sequencer_if.master rom,
    output logic [4:0]        note,
    output logic              note_stb,
    output logic              busy,
    output logic              done
);
    localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
    localparam int CNT_W    = $clog2(BEAT_DIV);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [4:0]        cur_note, cur_note_n;
    logic              long_note, long_note_n;
    logic [4:0]        beats_left, beats_left_n;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_n;
    logic [4:0]        note_n;
    logic              done_n, gap_n, tick;

    logic       end_flag;
    logic [4:0] word_code;
    logic [3:0] word_dur;

    assign end_flag  = rom.rom_data[9];
    assign word_code = rom.rom_data[8:4];
    assign word_dur  = rom.rom_data[3:0];
    assign tick      = (beat_cnt == CNT_W'(BEAT_DIV - 1));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_n      = state;
        addr_n       = addr;
        cur_note_n   = cur_note;
        long_note_n  = long_note;
        beats_left_n = beats_left;
        beat_cnt_n   = beat_cnt;
        done_n       = 1'b0;

        if (stop) begin
            state_n = IDLE;
        end else if (start) begin
            addr_n  = start_addr;
            state_n = FETCH;
        end else begin
            case (state)
                IDLE:  state_n = IDLE;
                FETCH: state_n = LATCH;
                LATCH: begin
                    if (end_flag) begin
                        if (loop_en) begin
                            addr_n  = start_addr;
                            state_n = FETCH;
                        end else begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        // Codes above high B are silent; a zero duration is the 16-beat note.
                        cur_note_n   = (word_code > 5'd21) ? 5'd0 : word_code;
                        beats_left_n = (word_dur == 4'd0) ? 5'd16 : {1'b0, word_dur};
                        long_note_n  = (word_dur != 4'd1);
                        beat_cnt_n   = '0;
                        state_n      = PLAY;
                    end
                end
                PLAY: begin
                    if (!pause) begin
                        if (tick) begin
                            beat_cnt_n = '0;
                            if (beats_left > 5'd1) begin
                                beats_left_n = beats_left - 5'd1;
                            end else begin
                                addr_n  = addr + 1'b1;
                                state_n = FETCH;
                            end
                        end else begin
                            beat_cnt_n = beat_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Outputs are computed from the next-state values so that note lines up with PLAY cycles.
        gap_n  = (GAP_EN != 0) && long_note_n && (beats_left_n == 5'd1);
        note_n = (state_n == PLAY && !pause && !gap_n) ? cur_note_n : 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            cur_note     <= 5'd0;
            long_note    <= 1'b0;
            beats_left   <= 5'd0;
            beat_cnt     <= '0;
            note         <= 5'd0;
            note_stb     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rom.rom_rd   <= 1'b0;
            rom.rom_addr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state        <= state_n;
            addr         <= addr_n;
            cur_note     <= cur_note_n;
            long_note    <= long_note_n;
            beats_left   <= beats_left_n;
            beat_cnt     <= beat_cnt_n;
            note         <= note_n;
            note_stb     <= (note_n != note);
            busy         <= (state_n != IDLE);
            done         <= done_n;
            rom.rom_rd   <= (state_n == FETCH);
            if (state_n == FETCH) rom.rom_addr <= addr_n;
        end
    end
endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: two instances (gap on / gap off) share stimulus and a score ROM;
// a note-level model is compared every cycle, plus hand-computed literal timelines.
module tb_music_sequencer;
    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, pause, loop_en;
    logic [7:0] start_addr;
    logic [9:0] rom [256];

    int  err_cnt = 0;
    int  chk_cnt = 0;
    bit  cmp_en  = 1'b0;

    always #5 clk = ~clk;

    music_sequencer_if #(.ADDR_W(8)) bus_g ();
    music_sequencer_if #(.ADDR_W(8)) bus_n ();

    logic [4:0] gap_note, nog_note;
    logic       gap_stb, gap_busy, gap_done, nog_stb, nog_busy, nog_done;

    music_sequencer #(.CLK_HZ(32), .BEAT_HZ(8), .ADDR_W(8), .GAP_EN(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .start_addr(start_addr), .rom(bus_g.master),
        .note(gap_note), .note_stb(gap_stb), .busy(gap_busy), .done(gap_done)
    );

    music_sequencer #(.CLK_HZ(32), .BEAT_HZ(8), .ADDR_W(8), .GAP_EN(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .start_addr(start_addr), .rom(bus_n.master),
        .note(nog_note), .note_stb(nog_stb), .busy(nog_busy), .done(nog_done)
    );

    always @(posedge clk) if (bus_g.rom_rd) bus_g.rom_data <= rom[bus_g.rom_addr];
    always @(posedge clk) if (bus_n.rom_rd) bus_n.rom_data <= rom[bus_n.rom_addr];

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Note-level model: idle, a two-cycle gap between words, or playing e cycles into a note.
    typedef enum {M_IDLE, M_BETW, M_PLAY} mmode_t;
    typedef struct {
        mmode_t mode;
        int     addr, cur, dur, e, k, note, raddr;
        bit     rd, done, stb;
    } mdl_t;

    mdl_t m_g, m_n;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.mode = M_IDLE; r.addr = 0; r.cur = 0; r.dur = 0; r.e = 0; r.k = 0;
        r.note = 0; r.raddr = 0; r.rd = 0; r.done = 0; r.stb = 0;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit gap_en);
        mdl_t       n = m;
        logic [9:0] w;
        bit         gap;
        n.done = 0;
        n.rd   = 0;
        if (stop) n.mode = M_IDLE;
        else if (start) begin
            n.mode = M_BETW; n.k = 0; n.addr = int'(start_addr);
        end else if (m.mode == M_BETW) begin
            if (m.k == 0) n.k = 1;
            else begin
                w = rom[m.addr];
                if (w[9]) begin
                    if (loop_en) begin n.addr = int'(start_addr); n.k = 0; end
                    else begin n.mode = M_IDLE; n.done = 1; end
                end else begin
                    n.mode = M_PLAY;
                    n.cur  = (int'(w[8:4]) > 21) ? 0 : int'(w[8:4]);
                    n.dur  = (w[3:0] == 0) ? 16 : int'(w[3:0]);
                    n.e    = 0;
                end
            end
        end else if (m.mode == M_PLAY && !pause) begin
            if (m.e + 1 == m.dur * BD) begin
                n.mode = M_BETW; n.k = 0; n.addr = (m.addr + 1) % 256;
            end else n.e = m.e + 1;
        end
        if (n.mode == M_BETW && n.k == 0) begin n.rd = 1; n.raddr = n.addr; end
        gap    = gap_en && n.dur >= 2 && n.e >= (n.dur - 1) * BD;
        n.note = (n.mode == M_PLAY && !pause && !gap) ? n.cur : 0;
        n.stb  = (n.note != m.note);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_g <= mdl_reset();
            m_n <= mdl_reset();
        end else begin
            m_g <= step(m_g, 1'b1);
            m_n <= step(m_n, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl.g.note", gap_note, m_g.note);
            check("mdl.g.stb", gap_stb, m_g.stb);
            check("mdl.g.busy", gap_busy, m_g.mode != M_IDLE);
            check("mdl.g.done", gap_done, m_g.done);
            check("mdl.g.rd", bus_g.rom_rd, m_g.rd);
            check("mdl.g.addr", bus_g.rom_addr, m_g.raddr);
            check("mdl.n.note", nog_note, m_n.note);
            check("mdl.n.stb", nog_stb, m_n.stb);
            check("mdl.n.busy", nog_busy, m_n.mode != M_IDLE);
            check("mdl.n.done", nog_done, m_n.done);
            check("mdl.n.rd", bus_n.rom_rd, m_n.rd);
            check("mdl.n.addr", bus_n.rom_addr, m_n.raddr);
        end
    end

    // Leaves the bench at the negedge where the FETCH cycle is visible (timeline index 0).
    task automatic pulse_start(input logic [7:0] sa);
        @(negedge clk);
        start = 1'b1; start_addr = sa;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_basic();
        for (int a = 0; a < 256; a++) rom[a] = 10'h200;
        rom[0] = {1'b0, 5'd10, 4'd2};
        rom[1] = {1'b0, 5'd12, 4'd1};
        rom[2] = {1'b1, 5'd0, 4'd0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0; start_addr = 8'd0;
        load_basic();
        repeat (3) @(negedge clk);
        check("rst.note", gap_note, 0);
        check("rst.stb", gap_stb, 0);
        check("rst.busy", gap_busy, 0);
        check("rst.done", gap_done, 0);
        check("rst.rd", bus_g.rom_rd, 0);
        check("rst.addr", bus_g.rom_addr, 0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);

        // Pause while idle does nothing.
        pause = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_pause.busy", gap_busy, 0);
        pause = 1'b0;

        // Basic sequence on both gap settings.
        pulse_start(8'd0);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            check("basic.g.note", gap_note, (i >= 2 && i < 6) ? 10 : (i >= 12 && i < 16) ? 12 : 0);
            check("basic.n.note", nog_note, (i >= 2 && i < 10) ? 10 : (i >= 12 && i < 16) ? 12 : 0);
            check("basic.g.stb", gap_stb, i == 2 || i == 6 || i == 12 || i == 16);
            check("basic.n.stb", nog_stb, i == 2 || i == 10 || i == 12 || i == 16);
            check("basic.done", gap_done, i == 18);
            check("basic.busy", gap_busy, i < 18);
        end

        // Zero duration means 16 beats; address wraps 255 -> 0.
        rom[255] = {1'b0, 5'd5, 4'd0};
        rom[0]   = {1'b1, 5'd0, 4'd0};
        pulse_start(8'd255);
        for (int i = 0; i < 70; i++) begin
            if (i > 0) @(negedge clk);
            check("wrap.n.note", nog_note, (i >= 2 && i < 66) ? 5 : 0);
            check("wrap.g.note", gap_note, (i >= 2 && i < 62) ? 5 : 0);
            if (i == 66) begin
                check("wrap.rd", bus_n.rom_rd, 1);
                check("wrap.addr", bus_n.rom_addr, 0);
            end
            check("wrap.done", nog_done, i == 68);
        end
        load_basic();

        // Pause for 10 cycles during the second cycle of note 10.
        pulse_start(8'd0);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            check("pause.g.note", gap_note, (i == 2 || i == 3 || i == 14 || i == 15) ? 10 : 0);
            check("pause.n.note", nog_note, (i == 2 || i == 3 || i >= 14) ? 10 : 0);
            check("pause.g.stb", gap_stb, i == 2 || i == 4 || i == 14 || i == 16);
            if (i == 3) pause = 1'b1;
            if (i == 13) pause = 1'b0;
        end
        repeat (20) @(negedge clk);
        check("pause.end.busy", gap_busy, 0);

        // Looping: end word refetches from start_addr, no done; then stop mid-note.
        loop_en = 1'b1;
        pulse_start(8'd0);
        for (int i = 0; i < 22; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 18) begin
                check("loop.rd", bus_g.rom_rd, 1);
                check("loop.addr", bus_g.rom_addr, 0);
            end
            if (i == 20) check("loop.note", gap_note, 10);
            check("loop.done", gap_done, 0);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; loop_en = 1'b0;
        check("stop.note", gap_note, 0);
        check("stop.busy", gap_busy, 0);
        check("stop.done", gap_done, 0);

        // start and stop together: stop wins.
        @(negedge clk);
        start = 1'b1; stop = 1'b1; start_addr = 8'd0;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop.busy", gap_busy, 0);
        check("startstop.rd", gap_busy, 0);
        @(negedge clk);
        check("startstop.busy2", nog_busy, 0);

        // Restart while ROM[1] plays.
        pulse_start(8'd0);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 13) begin
                check("restart.pre.note", gap_note, 12);
                check("restart.pre.addr", bus_g.rom_addr, 1);
            end
        end
        start = 1'b1; start_addr = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("restart.rd", bus_g.rom_rd, 1);
        check("restart.addr", bus_g.rom_addr, 0);
        check("restart.busy", gap_busy, 1);
        repeat (2) @(negedge clk);
        check("restart.note", gap_note, 10);

        // Asynchronous reset mid-note.
        #2 rst_n = 1'b0;
        #1;
        check("arst.g.note", gap_note, 0);
        check("arst.g.busy", gap_busy, 0);
        check("arst.n.note", nog_note, 0);
        check("arst.n.busy", nog_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("arst.after.busy", gap_busy, 0);
        check("arst.after.note", nog_note, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
